// File: rtl/cic_decim_strobed.sv
// Strobed CIC decimator, runtime rate 1..128, power-of-two gain normalisation (CIC_DECIM_ROUND_EN: round-half-up).
// Latency: N+2 enabled cycles from the group-completing strobe_in to strobe_out.
// No backpressure: enable low freezes all state, ignores strobe_in and masks strobe_out.
module cic_decim_strobed #(
    parameter int N     = 4,
    parameter int WIDTH = 18
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [7:0]              rate,
    input  logic                    strobe_in,
    input  logic signed [WIDTH-1:0] data_in,
    output logic                    strobe_out,
    output logic signed [WIDTH-1:0] data_out
);
    localparam int AW = WIDTH + 7 * N;
    localparam int SW = $clog2(7 * N + 1);

    function automatic logic [2:0] log2_ceil(input logic [7:0] r);
        logic [2:0] res;
        res = 3'd0;
        for (int i = 0; i < 7; i++)
            if (r > (8'd1 << i)) res = 3'(i + 1);
        return res;
    endfunction

    logic [7:0]           rate_clamped;
    logic [7:0]           rate_eff;
    logic [7:0]           rate_cur;
    logic [SW-1:0]        shift_q;
    logic [SW-1:0]        shift_cur;
    logic [6:0]           cnt;
    logic                 last;
    logic signed [AW-1:0] integ [N];
    logic                 dec_vld;
    logic [SW-1:0]        dec_sh;
    logic signed [AW-1:0] comb_x    [N];
    logic signed [AW-1:0] comb_y    [N];
    logic signed [AW-1:0] comb_prev [N];
    logic [SW-1:0]        comb_shin [N];
    logic [SW-1:0]        comb_sh   [N];
    logic [N-1:0]         comb_vin;
    logic [N-1:0]         comb_vld;
    logic signed [AW-1:0] rnd;
    logic                 out_vld;

    // The rate is picked up on the first strobe of each group, so a group always completes at the rate it started with.
    always_comb begin
        rate_clamped = rate;
        if (rate == 8'd0)
            rate_clamped = 8'd1;
        else if (rate > 8'd128)
            rate_clamped = 8'd128;
        rate_cur  = (cnt == 7'd0) ? rate_clamped : rate_eff;
        shift_cur = (cnt == 7'd0) ? SW'(N * int'(log2_ceil(rate_clamped))) : shift_q;
        last      = ({1'b0, cnt} == rate_cur - 8'd1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N; k++) integ[k] <= '0;
            cnt      <= '0;
            rate_eff <= 8'd1;
            shift_q  <= '0;
            dec_vld  <= 1'b0;
            dec_sh   <= '0;
        end else if (enable) begin
            dec_vld <= strobe_in & last;
            if (strobe_in) begin
                integ[0] <= integ[0] + {{(AW - WIDTH){data_in[WIDTH-1]}}, data_in};
                for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
                cnt <= last ? 7'd0 : cnt + 7'd1;
                if (cnt == 7'd0) begin
                    rate_eff <= rate_cur;
                    shift_q  <= shift_cur;
                end
                if (last) dec_sh <= shift_cur;
            end
        end
    end

    // The shift travels with each decimated sample so a rate change never re-scales an output already in flight.
    always_comb begin
        comb_x[0]    = integ[N-1];
        comb_vin[0]  = dec_vld;
        comb_shin[0] = dec_sh;
        for (int k = 1; k < N; k++) begin
            comb_x[k]    = comb_y[k-1];
            comb_vin[k]  = comb_vld[k-1];
            comb_shin[k] = comb_sh[k-1];
        end
    end

    always_comb begin
        rnd = comb_y[N-1];
`ifdef CIC_DECIM_ROUND_EN
        if (comb_sh[N-1] != '0)
            rnd = comb_y[N-1] + (AW'(1) << (comb_sh[N-1] - SW'(1)));
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            comb_vld <= '0;
            for (int k = 0; k < N; k++) begin
                comb_y[k]    <= '0;
                comb_prev[k] <= '0;
                comb_sh[k]   <= '0;
            end
            out_vld  <= 1'b0;
            data_out <= '0;
        end else if (enable) begin
            comb_vld <= comb_vin;
            for (int k = 0; k < N; k++) begin
                if (comb_vin[k]) begin
                    comb_y[k]    <= comb_x[k] - comb_prev[k];
                    comb_prev[k] <= comb_x[k];
                    comb_sh[k]   <= comb_shin[k];
                end
            end
            out_vld <= comb_vld[N-1];
            if (comb_vld[N-1])
                data_out <= WIDTH'(rnd >>> comb_sh[N-1]);
        end
    end

    assign strobe_out = out_vld & enable;

endmodule

// File: doc/cic_decim_strobed.md
# cic_decim_strobed

Strobe-driven, variable-rate CIC decimator that sits directly upstream of the halfband decimator in the receive DSP chain. It accepts one 18-bit signed sample per `strobe_in`, decimates by a runtime rate of 1..128, and normalises the CIC gain by a power-of-two shift. It emits 18-bit signed samples with a single-cycle `strobe_out` that feeds the halfband's `strobe_in`/`data_in` directly.

## Interface
- `N`, 4: number of integrator and comb stages (1..6).
- `WIDTH`, 18: input/output sample width.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  advance enable; when low, all state holds.
- `rate`  in  8  decimation rate; 0 is treated as 1, values >128 are treated as 128.
- `strobe_in`  in  1  input sample valid, one cycle per sample.
- `data_in`  in  WIDTH  signed input sample.
- `strobe_out`  out  1  output sample valid, single-cycle pulse.
- `data_out`  out  WIDTH  signed decimated sample.

## Operation
- Accumulator width is AW = WIDTH + 7·N, sign-extended from the input. All integrator and comb arithmetic is two's-complement modulo 2^AW; wrap-around is intended and cancels in the combs.
- Integrators:
  - on accepted `strobe_in` (`enable` high): integ[0] += sext(data_in), and integ[k] += integ[k-1] (old value), for k = 1..N-1.
  - No update without the strobe.
- Decimation counter (cnt, 0..127):
  - on accepted `strobe_in`, if cnt == rate_eff-1 then cnt <= 0 and a decimation event is generated; otherwise cnt++.
  - rate_eff is sampled only when cnt reloads to 0, so a `rate` change takes effect at the next group boundary. The current group completes at the old rate.
- Comb chain: N registered stages, each advanced by its own valid bit shifted from the decimation event. Stage k computes y = x − x_prev and then sets x_prev <= x. The differential delay is 1 decimated sample.
- Normalisation:
  - shift S = N·clog2(rate_eff), latched with rate_eff.
  - CIC gain rate^N ≤ 2^S, so the result always fits WIDTH.
  - data_out = comb_out >>> S (arithmetic).
- `enable` low:
  - integrators, counter, comb pipeline and valid bits hold.
  - `strobe_out` is driven 0.
  - `strobe_in` is ignored.
- Reset:
  - clears integrators, combs, cnt, valid bits, rate_eff := 1 and S := 0.
  - `strobe_out` = 0 and `data_out` = 0.
  - Mid-operation reset discards any in-flight sample; no stale `strobe_out` may appear afterwards.

## Timing
- Latency: `strobe_out` pulses exactly N+2 enabled cycles after the `strobe_in` that completes a group.
  - 1 cycle: integrator/counter.
  - N cycles: combs.
  - 1 cycle: shift/round register.
- `data_out` changes only in the cycle `strobe_out` is high, and holds between strobes.
- Back-to-back `strobe_in` every cycle is supported at any rate, including rate 1, which gives one output per cycle.
- A decimation event coinciding with a `rate` change uses the old rate for that event's output and the new rate thereafter.
- Output valid count: exactly floor(input strobes / rate_eff) per constant-rate run started from reset.

## Configuration
- Macro `CIC_DECIM_ROUND_EN`:
  - Defined: round-half-up before the shift; add 2^(S-1) when S>0, then >>> S.
  - Undefined: plain arithmetic-shift truncation (floor).
  - Latency is identical in both builds.

## Test plan
- rate=1, `strobe_in` every cycle, ramp 0,1,2,… → `data_out` reproduces the ramp; first `strobe_out` at N+2 cycles after the first strobe.
- rate=4, DC 1000, N=4 (S=8, gain 256) → after N settling outputs, `data_out`=1000 steadily; 64 input strobes yield 16 `strobe_out` pulses.
- rate=3, DC −1000, N=4 (gain 81, S=8) → settled output −316 with `CIC_DECIM_ROUND_EN`, −317 without.
- rate=8 running; `rate` changed to 2 mid-group → current group completes after 8 inputs, subsequent outputs every 2 inputs, settled DC value unchanged for a power-of-two rate.
- `strobe_in` every other cycle, `enable` dropped for 5 cycles mid-group → no `strobe_out` while low; output sequence identical to the uninterrupted run, shifted by 5 cycles.
- `reset` asserted asynchronously between a decimation event and its `strobe_out` → `strobe_out`/`data_out` go 0 immediately, the pending output is never emitted, and the first post-reset output matches a fresh run.
